// File: rtl/vga_arb_pkg.sv
// Shared types for the VGA/host memory arbiter: grant tags, host command record,
// default widths.
package vga_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 17;
  localparam int unsigned DATA_W_DEF     = 24;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_HOST
  } gnt_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } host_cmd_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Synchronous host command FIFO; full/empty resolved by an extra wrap bit on each pointer.
module arb_cmd_fifo
  import vga_arb_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter type         cmd_t = host_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     push_cmd,
  input  logic                     pop,
  output cmd_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t           mem_q [DEPTH];
  cmd_t           mem_d [DEPTH];
  logic [AW:0]    wptr_q, wptr_d;
  logic [AW:0]    rptr_q, rptr_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = push_cmd;
      wptr_d                = wptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: video reads win every cycle, queued host commands fill the gaps.
// Build option VGA_ARB_BLANK_WR_EN holds host writes at the queue head until blanking.
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          VGA_CLK,
  input  logic                          RST,
  input  logic                          DISP_ACTIVE,
  input  logic                          VID_REQ,
  input  logic [ADDR_W-1:0]             VID_ADDR,
  output logic                          VID_RVALID,
  output logic [DATA_W-1:0]             VID_RDATA,
  input  logic                          HOST_VALID,
  output logic                          HOST_READY,
  input  logic                          HOST_WE,
  input  logic [ADDR_W-1:0]             HOST_ADDR,
  input  logic [DATA_W-1:0]             HOST_WDATA,
  output logic                          HOST_RVALID,
  output logic [DATA_W-1:0]             HOST_RDATA,
  output logic [$clog2(FIFO_DEPTH):0]   HOST_LEVEL,
  output logic [ADDR_W-1:0]             MEM_ADDR,
  output logic                          MEM_WE,
  output logic [DATA_W-1:0]             MEM_WDATA,
  input  logic [DATA_W-1:0]             MEM_RDATA
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              push_cmd, head;
  logic              push, pop, full, empty, head_ok;
  gnt_e              gnt, tag_q, tag_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              vid_rvalid_q, vid_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d, host_rdata_q, host_rdata_d;

  assign push     = HOST_VALID && !full && !RST;
  assign push_cmd = '{we: HOST_WE, addr: HOST_ADDR, wdata: HOST_WDATA};

  arb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .cmd_t (cmd_t)
  ) u_fifo (
    .clk      (VGA_CLK),
    .rst      (RST),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (HOST_LEVEL)
  );

`ifdef VGA_ARB_BLANK_WR_EN
  assign head_ok = !head.we || !DISP_ACTIVE;
`else
  logic disp_unused;
  assign disp_unused = DISP_ACTIVE;
  assign head_ok     = 1'b1;
`endif

  // Host writes never return data, so they are tagged as NONE in the response pipe.
  always_comb begin
    gnt       = GNT_NONE;
    pop       = 1'b0;
    MEM_ADDR  = last_addr_q;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    if (RST) begin
      MEM_ADDR = '0;
    end else if (VID_REQ) begin
      gnt      = GNT_VID;
      MEM_ADDR = VID_ADDR;
    end else if (!empty && head_ok) begin
      gnt       = GNT_HOST;
      pop       = 1'b1;
      MEM_ADDR  = head.addr;
      MEM_WE    = head.we;
      MEM_WDATA = head.wdata;
    end
    tag_d       = (gnt == GNT_HOST && head.we) ? GNT_NONE : gnt;
    last_addr_d = MEM_ADDR;
  end

  always_comb begin
    vid_rvalid_d  = (tag_q == GNT_VID);
    host_rvalid_d = (tag_q == GNT_HOST);
    vid_rdata_d   = vid_rvalid_d  ? MEM_RDATA : vid_rdata_q;
    host_rdata_d  = host_rvalid_d ? MEM_RDATA : host_rdata_q;
  end

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      tag_q         <= GNT_NONE;
      last_addr_q   <= '0;
      vid_rvalid_q  <= 1'b0;
      vid_rdata_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      tag_q         <= tag_d;
      last_addr_q   <= last_addr_d;
      vid_rvalid_q  <= vid_rvalid_d;
      vid_rdata_q   <= vid_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign HOST_READY  = !full;
  assign VID_RVALID  = vid_rvalid_q;
  assign VID_RDATA   = vid_rdata_q;
  assign HOST_RVALID = host_rvalid_q;
  assign HOST_RDATA  = host_rdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based model. Honours VGA_ARB_BLANK_WR_EN.
module tb_vga_mem_arbiter;

  localparam int AW = 17;
  localparam int DW = 24;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst, disp, vid_req, vid_rvalid, host_valid, host_ready, host_we;
  logic          host_rvalid, mem_we;
  logic [AW-1:0] vid_addr, host_addr, mem_addr;
  logic [DW-1:0] vid_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic [2:0]    host_level;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .VGA_CLK(clk), .RST(rst), .DISP_ACTIVE(disp),
    .VID_REQ(vid_req), .VID_ADDR(vid_addr), .VID_RVALID(vid_rvalid), .VID_RDATA(vid_rdata),
    .HOST_VALID(host_valid), .HOST_READY(host_ready), .HOST_WE(host_we),
    .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata), .HOST_RVALID(host_rvalid),
    .HOST_RDATA(host_rdata), .HOST_LEVEL(host_level),
    .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
  );

  // RAM environment: 1-cycle read latency, read returns pre-write contents.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [23:0] ram_init(input int a);
    return 24'((a * 40503) ^ 24'h5A5A5A);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vid_req = 0; vid_addr = '0; host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  typedef struct {
    logic vid; logic [AW-1:0] vaddr;
    logic hv; logic hwe; logic [AW-1:0] haddr; logic [DW-1:0] hwd;
    logic e_rdy; logic [2:0] e_lvl; logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wd;
    logic e_vrv; logic [DW-1:0] e_vrd; logic e_hrv; logic [DW-1:0] e_hrd;
  } vec_t;

  function automatic vec_t row(input logic vid, input int vaddr, input logic hv, input logic hwe,
                               input int haddr, input int hwd, input logic e_rdy, input int e_lvl,
                               input logic e_we, input int e_addr, input int e_wd, input logic e_vrv,
                               input int e_vrd, input logic e_hrv, input int e_hrd);
    vec_t r;
    r.vid = vid; r.vaddr = AW'(vaddr); r.hv = hv; r.hwe = hwe; r.haddr = AW'(haddr);
    r.hwd = DW'(hwd); r.e_rdy = e_rdy; r.e_lvl = 3'(e_lvl); r.e_we = e_we;
    r.e_addr = AW'(e_addr); r.e_wd = DW'(e_wd); r.e_vrv = e_vrv; r.e_vrd = DW'(e_vrd);
    r.e_hrv = e_hrv; r.e_hrd = DW'(e_hrd);
    return r;
  endfunction

  function automatic logic [23:0] hand_mem(input int a);
    case (a)
      'h100:   return 24'h12AB34;
      'h101:   return 24'h000001;
      'h102:   return 24'h000002;
      'h103:   return 24'h000003;
      default: return ram_init(a);
    endcase
  endfunction

  typedef struct { logic we; int addr; logic [DW-1:0] wd; } mcmd_t;

  vec_t tbl [13];

  initial begin
    mcmd_t         q [$];
    mcmd_t         c;
    logic [DW-1:0] mm [int];
    logic          ev_v [4], eh_v [4];
    logic [DW-1:0] ev_d [4], eh_d [4];
    int            last_addr, sz, s, e_addr, e_wd;
    logic          e_we, ok;

    for (int i = 0; i < (1<<AW); i++) ram[i] = ram_init(i);
    idle(); disp = 0; rst = 1;

    // Reset state
    next(); next();
    @(negedge clk);
    chk("rst_ready", host_ready, 1); chk("rst_level", host_level, 0);
    chk("rst_vrv", vid_rvalid, 0);   chk("rst_hrv", host_rvalid, 0);
    chk("rst_we", mem_we, 0);        chk("rst_addr", mem_addr, 0);
    chk("rst_vrd", vid_rdata, 0);    chk("rst_hrd", host_rdata, 0);
    next(); rst = 0;

    // Fill FIFO under video load, push-when-full with pop, in-order drain, read back
    tbl[0]  = row(1,'h10, 1,1,'h100,'h654321, 1,0, 0,'h10, 0, 0,0, 0,0);
    tbl[1]  = row(1,'h11, 1,1,'h101,1,        1,1, 0,'h11, 0, 0,0, 0,0);
    tbl[2]  = row(1,'h12, 1,1,'h102,2,        1,2, 0,'h12, 0, 1,ram_init('h10), 0,0);
    tbl[3]  = row(1,'h13, 1,1,'h103,3,        1,3, 0,'h13, 0, 1,ram_init('h11), 0,0);
    tbl[4]  = row(1,'h14, 1,0,'h100,0,        0,4, 0,'h14, 0, 1,ram_init('h12), 0,0);
    tbl[5]  = row(0,0,    1,0,'h100,0,        0,4, 1,'h100,'h654321, 1,ram_init('h13), 0,0);
    tbl[6]  = row(0,0,    1,0,'h100,0,        1,3, 1,'h101,1, 1,ram_init('h14), 0,0);
    tbl[7]  = row(0,0,    0,0,0,0,            1,3, 1,'h102,2, 0,0, 0,0);
    tbl[8]  = row(0,0,    0,0,0,0,            1,2, 1,'h103,3, 0,0, 0,0);
    tbl[9]  = row(0,0,    0,0,0,0,            1,1, 0,'h100,0, 0,0, 0,0);
    tbl[10] = row(0,0,    0,0,0,0,            1,0, 0,'h100,0, 0,0, 0,0);
    tbl[11] = row(0,0,    0,0,0,0,            1,0, 0,'h100,0, 0,0, 1,'h654321);
    tbl[12] = row(0,0,    0,0,0,0,            1,0, 0,'h100,0, 0,0, 0,0);
    for (int i = 0; i < 13; i++) begin
      vid_req = tbl[i].vid; vid_addr = tbl[i].vaddr; host_valid = tbl[i].hv;
      host_we = tbl[i].hwe; host_addr = tbl[i].haddr; host_wdata = tbl[i].hwd;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), host_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_level", i), host_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].e_wd);
      chk($sformatf("tbl%0d_vrv", i), vid_rvalid, tbl[i].e_vrv);
      if (tbl[i].e_vrv) chk($sformatf("tbl%0d_vrd", i), vid_rdata, tbl[i].e_vrd);
      chk($sformatf("tbl%0d_hrv", i), host_rvalid, tbl[i].e_hrv);
      if (tbl[i].e_hrv) chk($sformatf("tbl%0d_hrd", i), host_rdata, tbl[i].e_hrd);
      next();
    end

    // Reset one cycle after a host read issues: its response must vanish
    idle(); host_valid = 1; host_addr = 'h200;
    @(negedge clk); next();
    host_addr = 'h201;
    @(negedge clk);
    chk("rmr_issue_addr", mem_addr, 'h200); chk("rmr_issue_we", mem_we, 0);
    next(); host_addr = 'h202; rst = 1;
    @(negedge clk); chk("rmr_hrv_in_rst", host_rvalid, 0);
    next(); rst = 0; idle();
    @(negedge clk);
    chk("rmr_hrv", host_rvalid, 0); chk("rmr_ready", host_ready, 1);
    chk("rmr_level", host_level, 0); chk("rmr_vrv", vid_rvalid, 0);
    next();
    @(negedge clk); chk("rmr_hrv2", host_rvalid, 0); chk("rmr_we2", mem_we, 0);
    next();

    // Write then read back with idle video: RVALID three cycles after read accept
    host_valid = 1; host_we = 1; host_addr = 'h100; host_wdata = 24'h12AB34;
    @(negedge clk); next();
    host_we = 0;
    @(negedge clk);
    chk("wr_we", mem_we, 1); chk("wr_addr", mem_addr, 'h100); chk("wr_data", mem_wdata, 'h12AB34);
    next(); idle();
    @(negedge clk); chk("rd_addr", mem_addr, 'h100); chk("rd_we", mem_we, 0);
    next(); @(negedge clk); chk("rd_hrv_early", host_rvalid, 0);
    next(); @(negedge clk); chk("rd_hrv", host_rvalid, 1); chk("rd_hrd", host_rdata, 'h12AB34);
    next(); @(negedge clk); chk("rd_hrv_after", host_rvalid, 0);
    next();

    // Continuous video stream, fixed two-cycle latency
    for (int n = 0; n <= 802; n++) begin
      vid_req = (n < 800); vid_addr = AW'(n < 800 ? n : 0);
      @(negedge clk);
      chk("vs_we", mem_we, 0);
      if (n < 800) chk("vs_addr", mem_addr, n);
      if (n >= 2 && n < 802) begin
        chk("vs_vrv", vid_rvalid, 1);
        chk("vs_vrd", vid_rdata, hand_mem(n - 2));
      end else begin
        chk("vs_vrv_idle", vid_rvalid, 0);
      end
      next();
    end
    idle();

    // Head write during active display, read queued behind it
    disp = 1; host_valid = 1; host_we = 1; host_addr = 'h150; host_wdata = 24'hABCDEF;
    @(negedge clk); next();
    host_we = 0;
`ifdef VGA_ARB_BLANK_WR_EN
    @(negedge clk); chk("bw_c1_we", mem_we, 0);
    next(); idle();
    @(negedge clk); chk("bw_c2_we", mem_we, 0); chk("bw_c2_level", host_level, 2);
    next(); @(negedge clk); chk("bw_c3_we", mem_we, 0); chk("bw_c3_hrv", host_rvalid, 0);
    next(); disp = 0;
    @(negedge clk);
    chk("bw_c4_we", mem_we, 1); chk("bw_c4_addr", mem_addr, 'h150); chk("bw_c4_wd", mem_wdata, 'hABCDEF);
    next(); disp = 1;
    @(negedge clk); chk("bw_c5_we", mem_we, 0); chk("bw_c5_addr", mem_addr, 'h150);
    next(); @(negedge clk); chk("bw_c6_hrv", host_rvalid, 0);
    next(); @(negedge clk); chk("bw_c7_hrv", host_rvalid, 1); chk("bw_c7_hrd", host_rdata, 'hABCDEF);
`else
    @(negedge clk);
    chk("bw_c1_we", mem_we, 1); chk("bw_c1_addr", mem_addr, 'h150); chk("bw_c1_wd", mem_wdata, 'hABCDEF);
    next(); idle();
    @(negedge clk); chk("bw_c2_we", mem_we, 0); chk("bw_c2_addr", mem_addr, 'h150);
    next(); @(negedge clk); chk("bw_c3_hrv", host_rvalid, 0);
    next(); @(negedge clk); chk("bw_c4_hrv", host_rvalid, 1); chk("bw_c4_hrd", host_rdata, 'hABCDEF);
`endif
    next(); idle(); disp = 0;

    // Randomized traffic against a queue model of the arbiter
    rst = 1; next(); next(); rst = 0;
    last_addr = 0;
    for (int i = 0; i < 4; i++) begin ev_v[i] = 0; eh_v[i] = 0; ev_d[i] = '0; eh_d[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vid_req    = ($urandom_range(0, 99) < 45);
      vid_addr   = AW'('h1F000 + $urandom_range(0, 15));
      disp       = 1'($urandom_range(0, 1));
      host_valid = 1'($urandom_range(0, 1));
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = AW'('h1F000 + $urandom_range(0, 15));
      host_wdata = DW'($urandom);
      @(negedge clk);
      s = cyc % 4;
      chk("rnd_vrv", vid_rvalid, ev_v[s]);
      if (ev_v[s]) chk("rnd_vrd", vid_rdata, ev_d[s]);
      chk("rnd_hrv", host_rvalid, eh_v[s]);
      if (eh_v[s]) chk("rnd_hrd", host_rdata, eh_d[s]);
      ev_v[s] = 0; eh_v[s] = 0;
      sz = q.size();
      chk("rnd_ready", host_ready, (sz < D) ? 1 : 0);
      chk("rnd_level", host_level, sz);
      e_we = 0; e_wd = 0; e_addr = last_addr;
      if (vid_req) begin
        e_addr = int'(vid_addr);
        ev_v[(cyc + 2) % 4] = 1;
        ev_d[(cyc + 2) % 4] = mm.exists(e_addr) ? mm[e_addr] : ram_init(e_addr);
      end else if (sz > 0) begin
`ifdef VGA_ARB_BLANK_WR_EN
        ok = !q[0].we || !disp;
`else
        ok = 1;
`endif
        if (ok) begin
          c = q.pop_front();
          e_addr = c.addr;
          if (c.we) begin
            e_we = 1; e_wd = int'(c.wd); mm[c.addr] = c.wd;
          end else begin
            eh_v[(cyc + 2) % 4] = 1;
            eh_d[(cyc + 2) % 4] = mm.exists(c.addr) ? mm[c.addr] : ram_init(c.addr);
          end
        end
      end
      last_addr = e_addr;
      chk("rnd_we", mem_we, e_we);
      chk("rnd_addr", mem_addr, e_addr);
      if (e_we) chk("rnd_wdata", mem_wdata, e_wd);
      if (host_valid && sz < D) begin
        c.we = host_we; c.addr = int'(host_addr); c.wd = host_wdata;
        q.push_back(c);
      end
      next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
